// File: rtl/ext_mem_loader.sv
// Host-side sequencer for the CPU external memory ports: loads the instruction and data images,
// runs the core for a set number of cycles, then streams data-memory words back out.
module ext_mem_loader #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] imem_words,
  input  logic [CNT_W-1:0] dmem_words,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic [CNT_W-1:0] dump_words,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             cpu_enable,
  output logic [31:0]      addr_ext,
  output logic [31:0]      wdata_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      addr_ext_2,
  output logic [31:0]      wdata_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  input  logic [31:0]      rdata_ext_2,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    StIdle,
    StLoadI,
    StLoadD,
    StRun,
    StRdReq,
    StRdWait,
    StOut
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] imem_cnt_q, dmem_cnt_q, run_cnt_q, dump_cnt_q, idx_q;

  state_e      after_start, after_load_i, after_load_d, after_run;
  logic        hs;
  logic [31:0] idx_addr, idx_next_addr;

  // Each stage hands over to the next stage with a nonzero count, or back to idle.
  always_comb begin
    after_run    = (dump_cnt_q != '0) ? StRdReq : StIdle;
    after_load_d = (run_cnt_q != '0) ? StRun : after_run;
    after_load_i = (dmem_cnt_q != '0) ? StLoadD : after_load_d;
    if (imem_words != '0)      after_start = StLoadI;
    else if (dmem_words != '0) after_start = StLoadD;
    else if (run_cycles != '0) after_start = StRun;
    else if (dump_words != '0) after_start = StRdReq;
    else                       after_start = StIdle;
  end

  assign in_ready      = (state_q == StLoadI) || (state_q == StLoadD);
  assign busy          = (state_q != StIdle);
  assign hs            = in_valid & in_ready;
  assign ren_ext       = 1'b0;
  assign idx_addr      = 32'(idx_q) << 2;
  assign idx_next_addr = 32'(idx_q + CNT_W'(1)) << 2;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= StIdle;
      imem_cnt_q  <= '0;
      dmem_cnt_q  <= '0;
      run_cnt_q   <= '0;
      dump_cnt_q  <= '0;
      idx_q       <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      cpu_enable  <= 1'b0;
      addr_ext    <= '0;
      wdata_ext   <= '0;
      wen_ext     <= 1'b0;
      addr_ext_2  <= '0;
      wdata_ext_2 <= '0;
      wen_ext_2   <= 1'b0;
      ren_ext_2   <= 1'b0;
      done        <= 1'b0;
    end else begin
      wen_ext   <= 1'b0;
      wen_ext_2 <= 1'b0;
      done      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            imem_cnt_q <= imem_words;
            dmem_cnt_q <= dmem_words;
            run_cnt_q  <= run_cycles;
            dump_cnt_q <= dump_words;
            idx_q      <= '0;
            state_q    <= after_start;
            done       <= (after_start == StIdle);
          end
        end
        StLoadI: begin
          if (hs) begin
            wen_ext   <= 1'b1;
            addr_ext  <= idx_addr;
            wdata_ext <= in_data;
            if (idx_q == imem_cnt_q - CNT_W'(1)) begin
              idx_q   <= '0;
              state_q <= after_load_i;
              done    <= (after_load_i == StIdle);
            end else begin
              idx_q <= idx_q + CNT_W'(1);
            end
          end
        end
        StLoadD: begin
          if (hs) begin
            wen_ext_2   <= 1'b1;
            addr_ext_2  <= idx_addr;
            wdata_ext_2 <= in_data;
            if (idx_q == dmem_cnt_q - CNT_W'(1)) begin
              idx_q   <= '0;
              state_q <= after_load_d;
              done    <= (after_load_d == StIdle);
            end else begin
              idx_q <= idx_q + CNT_W'(1);
            end
          end
        end
        StRun: begin
          // First RUN cycle keeps the core stopped so a trailing load write lands first.
          if (idx_q != run_cnt_q) begin
            cpu_enable <= 1'b1;
            idx_q      <= idx_q + CNT_W'(1);
          end else begin
            cpu_enable <= 1'b0;
            idx_q      <= '0;
            state_q    <= after_run;
            done       <= (after_run == StIdle);
          end
        end
        StRdReq: begin
          // Entry from OUT pre-issues the read; any other entry issues it here, which also keeps
          // the read clear of a data-memory write still draining from LOAD_D.
          if (!ren_ext_2) begin
            ren_ext_2  <= 1'b1;
            addr_ext_2 <= idx_addr;
          end else begin
            ren_ext_2 <= 1'b0;
            state_q   <= StRdWait;
          end
        end
        StRdWait: begin
          out_data  <= rdata_ext_2;
          out_valid <= 1'b1;
          state_q   <= StOut;
        end
        StOut: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx_q == dump_cnt_q - CNT_W'(1)) begin
              idx_q   <= '0;
              state_q <= StIdle;
              done    <= 1'b1;
            end else begin
              idx_q      <= idx_q + CNT_W'(1);
              ren_ext_2  <= 1'b1;
              addr_ext_2 <= idx_next_addr;
              state_q    <= StRdReq;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_mem_loader.sv
// Bench for ext_mem_loader: table-driven and random load/run/dump sequences checked against
// expected write lists, run length and read-back data derived from the stimulus.
module tb_ext_mem_loader;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             arst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] imem_words = '0, dmem_words = '0, run_cycles = '0, dump_words = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_data;
  logic             cpu_enable;
  logic [31:0]      addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
  logic             wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0]      rdata_ext_2 = '0;
  logic             busy, done;

  ext_mem_loader #(.CNT_W(CNT_W)) dut (
    .clk(clk), .arst_n(arst_n), .start(start),
    .imem_words(imem_words), .dmem_words(dmem_words),
    .run_cycles(run_cycles), .dump_words(dump_words),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cpu_enable(cpu_enable),
    .addr_ext(addr_ext), .wdata_ext(wdata_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .addr_ext_2(addr_ext_2), .wdata_ext_2(wdata_ext_2), .wen_ext_2(wen_ext_2),
    .ren_ext_2(ren_ext_2), .rdata_ext_2(rdata_ext_2),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ni; int nd; int nr; int nu;
    bit gap; bit stall; int stall_word; bit repulse; bit fixed; bit a0;
  } vec_t;

  typedef struct { int cyc; logic [31:0] addr; logic [31:0] data; } wr_t;

  int n_checks = 0, n_errors = 0;

  logic [31:0] mem_d [64];
  logic [31:0] ref_d [64];
  logic [31:0] stream [$];
  wr_t         iw_q [$], dw_q [$];
  int          hs_q [$], out_cyc_q [$];
  logic [31:0] out_q [$];
  int cyc = 0, sptr, en_cnt, en_runs, ren_cnt, done_cnt, done_cyc, last_en_cyc, last_wr_cyc;
  int bad_overlap, bad_stall, busy_drop, stall_word, stall_left;
  bit gap_mode, stall_mode, prev_en, prev_stall, ren_pend, in_seq;
  logic [31:0] prev_out, ren_val;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic clear_mon();
    stream.delete(); iw_q.delete(); dw_q.delete(); hs_q.delete();
    out_q.delete(); out_cyc_q.delete();
    sptr = 0; en_cnt = 0; en_runs = 0; ren_cnt = 0; done_cnt = 0; done_cyc = -1;
    last_en_cyc = -1; last_wr_cyc = -1; bad_overlap = 0; bad_stall = 0; busy_drop = 0;
    stall_word = -1; stall_left = 0; gap_mode = 0; stall_mode = 0; prev_en = 0;
    prev_stall = 0; in_seq = 0;
  endtask

  // One clock: drive and observe at the falling edge, present read data just after the rise.
  task automatic tick();
    wr_t w;
    @(negedge clk);
    cyc++;
    in_valid = (sptr < stream.size()) && (!gap_mode || (cyc % 2 == 0));
    in_data  = (sptr < stream.size()) ? stream[sptr] : 32'h0;
    if (in_valid && in_ready) begin
      hs_q.push_back(cyc);
      sptr++;
    end
    out_ready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (stall_word >= 0 && out_q.size() == stall_word && out_valid && stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end
    if (prev_stall && (!out_valid || out_data !== prev_out)) bad_stall++;
    prev_stall = out_valid && !out_ready;
    prev_out   = out_data;
    if (out_valid && out_ready) begin
      out_q.push_back(out_data);
      out_cyc_q.push_back(cyc);
    end
    if (wen_ext) begin
      w.cyc = cyc; w.addr = addr_ext; w.data = wdata_ext;
      iw_q.push_back(w);
      last_wr_cyc = cyc;
    end
    if (wen_ext_2) begin
      w.cyc = cyc; w.addr = addr_ext_2; w.data = wdata_ext_2;
      dw_q.push_back(w);
      mem_d[addr_ext_2[7:2]] = wdata_ext_2;
      last_wr_cyc = cyc;
    end
    if (ren_ext || (wen_ext_2 && ren_ext_2)) bad_overlap++;
    if (cpu_enable) begin
      en_cnt++;
      if (!prev_en) en_runs++;
      last_en_cyc = cyc;
      if (wen_ext || wen_ext_2 || !busy) bad_overlap++;
    end
    prev_en  = cpu_enable;
    ren_pend = ren_ext_2;
    if (ren_ext_2) begin
      ren_cnt++;
      ren_val = mem_d[addr_ext_2[7:2]];
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (in_seq) begin
      if (done) in_seq = 0;
      else if (!busy) busy_drop++;
    end
    @(posedge clk);
    #1;
    rdata_ext_2 = ren_pend ? ren_val : (32'hBAD0_0000 | 32'(cyc));
  endtask

  task automatic run_seq(input vec_t v, input string tag);
    logic [31:0] fx [3];
    logic [31:0] val;
    int start_cyc, dd;
    bit repulsed;
    fx[0] = 32'h2008_0005; fx[1] = 32'h2009_0007; fx[2] = 32'h0109_5020;
    clear_mon();
    for (int w = 0; w < 64; w++) begin
      val = (v.a0 && w < 4) ? 32'hA0 + 32'(w) : $urandom;
      mem_d[w] = val;
      ref_d[w] = val;
    end
    for (int k = 0; k < v.ni + v.nd; k++) stream.push_back((v.fixed && k < 3) ? fx[k] : $urandom);
    for (int w = 0; w < v.nd; w++) ref_d[w] = stream[v.ni + w];
    gap_mode = v.gap; stall_mode = v.stall; stall_word = v.stall_word; stall_left = 5;
    imem_words = CNT_W'(v.ni); dmem_words = CNT_W'(v.nd);
    run_cycles = CNT_W'(v.nr); dump_words = CNT_W'(v.nu);
    start = 1'b1;
    tick();
    start_cyc = cyc;
    start = 1'b0;
    imem_words = CNT_W'($urandom); dmem_words = CNT_W'($urandom);
    run_cycles = CNT_W'($urandom); dump_words = CNT_W'($urandom);
    in_seq = 1;
    repulsed = 0;
    for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
      if (v.repulse && en_cnt > 0 && !repulsed) begin
        imem_words = 7; dmem_words = 7; run_cycles = 7; dump_words = 7;
        start = 1'b1;
        tick();
        start = 1'b0;
        repulsed = 1;
      end else begin
        tick();
      end
    end
    for (int k = 0; k < 8; k++) tick();

    chk({tag, "_done_count"}, done_cnt, 1);
    if (v.repulse && v.nr > 0) chk({tag, "_repulse_in_run"}, 32'(repulsed), 1);
    chk({tag, "_hs_count"}, hs_q.size(), v.ni + v.nd);
    chk({tag, "_imem_wr_count"}, iw_q.size(), v.ni);
    for (int k = 0; k < iw_q.size() && k < v.ni && k < hs_q.size(); k++) begin
      chk({tag, $sformatf("_imem_addr%0d", k)}, iw_q[k].addr, 32'(4 * k));
      chk({tag, $sformatf("_imem_data%0d", k)}, iw_q[k].data, stream[k]);
      chk({tag, $sformatf("_imem_lag%0d", k)}, iw_q[k].cyc, hs_q[k] + 1);
    end
    chk({tag, "_dmem_wr_count"}, dw_q.size(), v.nd);
    for (int k = 0; k < dw_q.size() && k < v.nd && v.ni + k < hs_q.size(); k++) begin
      chk({tag, $sformatf("_dmem_addr%0d", k)}, dw_q[k].addr, 32'(4 * k));
      chk({tag, $sformatf("_dmem_data%0d", k)}, dw_q[k].data, stream[v.ni + k]);
      chk({tag, $sformatf("_dmem_lag%0d", k)}, dw_q[k].cyc, hs_q[v.ni + k] + 1);
    end
    chk({tag, "_enable_cycles"}, en_cnt, v.nr);
    chk({tag, "_enable_bursts"}, en_runs, (v.nr != 0) ? 1 : 0);
    chk({tag, "_read_count"}, ren_cnt, v.nu);
    chk({tag, "_out_count"}, out_q.size(), v.nu);
    for (int k = 0; k < out_q.size() && k < v.nu; k++)
      chk({tag, $sformatf("_out_data%0d", k)}, out_q[k], ref_d[k]);
    if (!v.stall && v.stall_word < 0)
      for (int k = 1; k < out_cyc_q.size(); k++)
        chk({tag, $sformatf("_out_spacing%0d", k)}, out_cyc_q[k] - out_cyc_q[k-1], 3);
    if (v.stall_word >= 0) chk({tag, "_stall_consumed"}, stall_left, 0);
    if (v.nu > 0) begin
      if (out_cyc_q.size() > 0)
        chk({tag, "_done_after_out"}, done_cyc, out_cyc_q[out_cyc_q.size()-1] + 1);
    end else if (v.nr > 0) begin
      chk({tag, "_done_after_run"}, done_cyc, last_en_cyc + 1);
    end else if (v.ni + v.nd > 0) begin
      dd = done_cyc - last_wr_cyc;
      chk({tag, "_done_after_load"}, 32'(dd >= 0 && dd <= 1), 1);
    end else begin
      chk({tag, "_done_empty"}, done_cyc, start_cyc + 1);
    end
    chk({tag, "_overlap"}, bad_overlap, 0);
    chk({tag, "_stall_stable"}, bad_stall, 0);
    chk({tag, "_busy_held"}, busy_drop, 0);
    chk({tag, "_idle_after"}, {31'b0, busy}, 0);
  endtask

  vec_t vecs [9];
  vec_t rv;

  initial begin
    vecs[0] = '{ni: 3, nd: 0, nr: 0,  nu: 0, gap: 0, stall: 0, stall_word: -1, repulse: 0, fixed: 1, a0: 0};
    vecs[1] = '{ni: 0, nd: 2, nr: 0,  nu: 0, gap: 1, stall: 0, stall_word: -1, repulse: 0, fixed: 0, a0: 0};
    vecs[2] = '{ni: 0, nd: 0, nr: 10, nu: 0, gap: 0, stall: 0, stall_word: -1, repulse: 0, fixed: 0, a0: 0};
    vecs[3] = '{ni: 0, nd: 0, nr: 0,  nu: 4, gap: 0, stall: 0, stall_word: 1,  repulse: 0, fixed: 0, a0: 1};
    vecs[4] = '{ni: 2, nd: 2, nr: 5,  nu: 2, gap: 0, stall: 0, stall_word: -1, repulse: 1, fixed: 0, a0: 0};
    vecs[5] = '{ni: 0, nd: 0, nr: 0,  nu: 0, gap: 0, stall: 0, stall_word: -1, repulse: 0, fixed: 0, a0: 0};
    vecs[6] = '{ni: 4, nd: 3, nr: 0,  nu: 3, gap: 1, stall: 1, stall_word: -1, repulse: 0, fixed: 0, a0: 0};
    vecs[7] = '{ni: 1, nd: 0, nr: 0,  nu: 1, gap: 0, stall: 0, stall_word: -1, repulse: 0, fixed: 0, a0: 0};
    vecs[8] = '{ni: 0, nd: 3, nr: 0,  nu: 3, gap: 0, stall: 0, stall_word: -1, repulse: 0, fixed: 0, a0: 0};
    clear_mon();

    #1;
    chk("reset_ctrl", {24'b0, cpu_enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2, out_valid, done, busy}, 0);
    chk("reset_in_ready", {31'b0, in_ready}, 0);
    chk("reset_addr_ext", addr_ext, 0);
    chk("reset_addr_ext_2", addr_ext_2, 0);
    chk("reset_out_data", out_data, 0);
    #19 arst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_seq(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 12; i++) begin
      rv.ni = $urandom_range(0, 5); rv.nd = $urandom_range(0, 5);
      rv.nr = $urandom_range(0, 8); rv.nu = $urandom_range(0, 5);
      rv.gap = 1'($urandom_range(0, 1)); rv.stall = 1'($urandom_range(0, 1));
      rv.stall_word = -1; rv.repulse = 1'($urandom_range(0, 1)); rv.fixed = 0; rv.a0 = 0;
      run_seq(rv, $sformatf("rnd%0d", i));
    end

    // Asynchronous reset in the middle of RUN.
    clear_mon();
    imem_words = 0; dmem_words = 0; run_cycles = 20; dump_words = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 100 && en_cnt < 3; k++) tick();
    chk("midrun_running", {31'b0, cpu_enable}, 1);
    arst_n = 1'b0;
    #1;
    chk("midrun_enable_low", {31'b0, cpu_enable}, 0);
    chk("midrun_busy_low", {31'b0, busy}, 0);
    chk("midrun_ports_low", {27'b0, wen_ext, wen_ext_2, ren_ext_2, out_valid, done}, 0);
    tick(); tick(); tick();
    arst_n = 1'b1;
    clear_mon();
    for (int k = 0; k < 10; k++) tick();
    chk("midrun_no_done", done_cnt, 0);
    chk("midrun_stays_idle", en_cnt, 0);
    rv = '{ni: 1, nd: 1, nr: 3, nu: 1, gap: 0, stall: 0, stall_word: -1, repulse: 0, fixed: 0, a0: 0};
    run_seq(rv, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
